// File: rtl/output_soft_mute.sv
// Per-channel gain and soft-mute stage: linear gain ramp per valid sample,
// 2-cycle multiply/shift pipeline and saturating per-channel clip counters.
module output_soft_mute #(
  parameter int unsigned STEP        = 1,
  parameter logic [31:0] CLIP_THRESH = 32'h7F00_0000
) (
  input  logic        clk_dac_hs,
  input  logic        rst_n,
  input  logic [31:0] audio_left_in,
  input  logic [31:0] audio_right_in,
  input  logic        audio_valid_in,
  input  logic        mute_req,
  input  logic [8:0]  volume,
  input  logic        clear_clip,
  output logic [31:0] audio_left_out,
  output logic [31:0] audio_right_out,
  output logic        audio_valid_out,
  output logic [8:0]  gain_out,
  output logic [1:0]  state_out,
  output logic        ramp_done,
  output logic [15:0] clip_count_left,
  output logic [15:0] clip_count_right
);

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [8:0] STEP_W = 9'(STEP);

  state_t state_q, state_d;
  logic [8:0]  gain_q, gain_d;
  logic        ramp_done_q, ramp_done_d;
  logic [8:0]  target;
  logic [8:0]  diff;

  logic signed [40:0] prod_left_q, prod_left_d;
  logic signed [40:0] prod_right_q, prod_right_d;
  logic        valid1_q, valid1_d;
  logic [31:0] out_left_q, out_left_d;
  logic [31:0] out_right_q, out_right_d;
  logic        valid_out_q, valid_out_d;
  logic [15:0] clip_left_q, clip_left_d;
  logic [15:0] clip_right_q, clip_right_d;
  logic [15:0] clip_cnt_left_q, clip_cnt_right_q;

  // Magnitude needs 33 bits so the most negative sample maps to 2^31.
  function automatic logic [32:0] mag33(input logic [31:0] v);
    mag33 = v[31] ? (33'd0 - {1'b1, v}) : {1'b0, v};
  endfunction

  always_comb begin
    target      = mute_req ? 9'd0 : ((volume > 9'd256) ? 9'd256 : volume);
    diff        = 9'd0;
    gain_d      = gain_q;
    state_d     = state_q;
    ramp_done_d = 1'b0;
    if (audio_valid_in) begin
      if (gain_q < target) begin
        diff   = target - gain_q;
        gain_d = gain_q + ((diff < STEP_W) ? diff : STEP_W);
      end else if (gain_q > target) begin
        diff   = gain_q - target;
        gain_d = gain_q - ((diff < STEP_W) ? diff : STEP_W);
      end
      if (gain_d == target)     state_d = (target == 9'd0) ? MUTED : ACTIVE;
      else if (gain_d < target) state_d = RAMP_UP;
      else                      state_d = RAMP_DOWN;
      ramp_done_d = ((state_q == RAMP_UP) || (state_q == RAMP_DOWN)) &&
                    ((state_d == MUTED) || (state_d == ACTIVE));
    end
  end

  // Samples are scaled by the gain in effect before this cycle's update.
  always_comb begin
    prod_left_d  = $signed({{9{audio_left_in[31]}}, audio_left_in}) *
                   $signed({32'd0, gain_q});
    prod_right_d = $signed({{9{audio_right_in[31]}}, audio_right_in}) *
                   $signed({32'd0, gain_q});
    valid1_d     = audio_valid_in;
    out_left_d   = prod_left_q[39:8];
    out_right_d  = prod_right_q[39:8];
    valid_out_d  = valid1_q;
  end

  always_comb begin
    clip_left_d  = clip_cnt_left_q;
    clip_right_d = clip_cnt_right_q;
    if (clear_clip) begin
      clip_left_d  = 16'd0;
      clip_right_d = 16'd0;
    end else if (valid1_q) begin
      if (mag33(out_left_d) >= {1'b0, CLIP_THRESH} && clip_cnt_left_q != 16'hFFFF)
        clip_left_d = clip_cnt_left_q + 16'd1;
      if (mag33(out_right_d) >= {1'b0, CLIP_THRESH} && clip_cnt_right_q != 16'hFFFF)
        clip_right_d = clip_cnt_right_q + 16'd1;
    end
  end

  always_ff @(posedge clk_dac_hs or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= MUTED;
      gain_q           <= 9'd0;
      ramp_done_q      <= 1'b0;
      prod_left_q      <= '0;
      prod_right_q     <= '0;
      valid1_q         <= 1'b0;
      out_left_q       <= 32'd0;
      out_right_q      <= 32'd0;
      valid_out_q      <= 1'b0;
      clip_cnt_left_q  <= 16'd0;
      clip_cnt_right_q <= 16'd0;
    end else begin
      state_q          <= state_d;
      gain_q           <= gain_d;
      ramp_done_q      <= ramp_done_d;
      if (audio_valid_in) begin
        prod_left_q  <= prod_left_d;
        prod_right_q <= prod_right_d;
      end
      valid1_q         <= valid1_d;
      if (valid1_q) begin
        out_left_q  <= out_left_d;
        out_right_q <= out_right_d;
      end
      valid_out_q      <= valid_out_d;
      clip_cnt_left_q  <= clip_left_d;
      clip_cnt_right_q <= clip_right_d;
    end
  end

  logic unused_prod_bits;
  assign unused_prod_bits = ^{prod_left_q[40], prod_left_q[7:0],
                              prod_right_q[40], prod_right_q[7:0]};

  assign audio_left_out   = out_left_q;
  assign audio_right_out  = out_right_q;
  assign audio_valid_out  = valid_out_q;
  assign gain_out         = gain_q;
  assign state_out        = state_q;
  assign ramp_done        = ramp_done_q;
  assign clip_count_left  = clip_cnt_left_q;
  assign clip_count_right = clip_cnt_right_q;

endmodule

// File: tb/tb_output_soft_mute.sv
// Self-checking bench for output_soft_mute: STEP=1 and STEP=16 instances
// driven from shared stimulus, directed vectors plus ramp/clip/reset sequences.
module tb_output_soft_mute;

  logic        clk_dac_hs = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] audio_left_in = '0, audio_right_in = '0;
  logic        audio_valid_in = 1'b0, mute_req = 1'b0, clear_clip = 1'b0;
  logic [8:0]  volume = '0;

  logic [31:0] l1, r1, l16, r16;
  logic        v1, v16, rd1, rd16;
  logic [8:0]  g1, g16;
  logic [1:0]  s1, s16;
  logic [15:0] cl1, cr1, cl16, cr16;

  int checks = 0;
  int failures = 0;

  always #5 clk_dac_hs = ~clk_dac_hs;

  output_soft_mute #(.STEP(1)) dut1 (
    .clk_dac_hs(clk_dac_hs), .rst_n(rst_n),
    .audio_left_in(audio_left_in), .audio_right_in(audio_right_in),
    .audio_valid_in(audio_valid_in), .mute_req(mute_req), .volume(volume),
    .clear_clip(clear_clip),
    .audio_left_out(l1), .audio_right_out(r1), .audio_valid_out(v1),
    .gain_out(g1), .state_out(s1), .ramp_done(rd1),
    .clip_count_left(cl1), .clip_count_right(cr1));

  output_soft_mute #(.STEP(16)) dut16 (
    .clk_dac_hs(clk_dac_hs), .rst_n(rst_n),
    .audio_left_in(audio_left_in), .audio_right_in(audio_right_in),
    .audio_valid_in(audio_valid_in), .mute_req(mute_req), .volume(volume),
    .clear_clip(clear_clip),
    .audio_left_out(l16), .audio_right_out(r16), .audio_valid_out(v16),
    .gain_out(g16), .state_out(s16), .ramp_done(rd16),
    .clip_count_left(cl16), .clip_count_right(cr16));

  typedef struct {
    logic [8:0]  vol;
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] exp_left;
    logic [31:0] exp_right;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk_dac_hs);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] left, input logic [31:0] right,
                               input logic valid);
    audio_left_in  = left;
    audio_right_in = right;
    audio_valid_in = valid;
  endtask

  // Feed zero samples until the selected instance reaches gain g (bounded).
  task automatic settleGain(input bit use16, input logic [8:0] g);
    int n;
    n = 0;
    while (n < 600 && (use16 ? g16 : g1) != g) begin
      applyStimulus(32'd0, 32'd0, 1'b1);
      tick();
      n++;
    end
    applyStimulus(32'd0, 32'd0, 1'b0);
    checkOutput("settle_gain", use16 ? g16 : g1, g);
  endtask

  initial begin
    int exp_g;
    int s3_count;
    int rd_count;

    vecs[0] = '{9'd128, 32'hF000_0000, 32'hFFFF_FFFF, 32'hF800_0000, 32'hFFFF_FFFF};
    vecs[1] = '{9'd128, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 32'h0000_0000};
    vecs[2] = '{9'd128, 32'h8000_0000, 32'hFFFF_FFFD, 32'hC000_0000, 32'hFFFF_FFFE};
    vecs[3] = '{9'd256, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[4] = '{9'd64,  32'h4000_0000, 32'hFFFF_FF00, 32'h1000_0000, 32'hFFFF_FFC0};
    vecs[5] = '{9'd0,   32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{9'd1,   32'h0000_0100, 32'hFFFF_FF01, 32'h0000_0001, 32'hFFFF_FFFF};

    // Reset state
    repeat (3) tick();
    checkOutput("rst_left", l1, 0);
    checkOutput("rst_right", r1, 0);
    checkOutput("rst_valid", v1, 0);
    checkOutput("rst_gain", g1, 0);
    checkOutput("rst_state", s1, 0);
    checkOutput("rst_ramp_done", rd1, 0);
    checkOutput("rst_clip_l", cl1, 0);
    checkOutput("rst_clip_r", cr1, 0);

    // Ramp up from reset at STEP=1
    mute_req = 1'b0;
    volume   = 9'd256;
    applyStimulus(32'h1000_0000, 32'h1000_0000, 1'b1);
    rst_n = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      tick();
      checkOutput("ramp_gain", g1, (i > 256) ? 256 : i);
      checkOutput("ramp_state", s1, (i < 256) ? 1 : 2);
      checkOutput("ramp_done_up", rd1, (i == 256) ? 1 : 0);
      checkOutput("ramp_valid", v1, (i >= 2) ? 1 : 0);
      if (i >= 2)
        checkOutput("ramp_out", l1, 64'(((i - 2) > 256 ? 256 : (i - 2))) << 20);
    end

    // Mute from ACTIVE at unity
    mute_req = 1'b1;
    s3_count = 0;
    rd_count = 0;
    for (int j = 1; j <= 258; j++) begin
      tick();
      if (s1 == 2'd3) s3_count++;
      if (rd1) rd_count++;
      checkOutput("mute_gain", g1, (j >= 256) ? 0 : 256 - j);
      checkOutput("mute_state", s1, (j < 256) ? 3 : 0);
    end
    checkOutput("mute_state3_len", s3_count, 255);
    checkOutput("mute_ramp_done_cnt", rd_count, 1);
    checkOutput("mute_out_zero", l1, 0);
    mute_req = 1'b0;

    // Table-driven arithmetic vectors
    for (int k = 0; k < 7; k++) begin
      volume = vecs[k].vol;
      settleGain(1'b0, vecs[k].vol);
      applyStimulus(vecs[k].left, vecs[k].right, 1'b1);
      tick();
      applyStimulus(32'd0, 32'd0, 1'b0);
      tick();
      checkOutput("vec_valid", v1, 1);
      checkOutput("vec_left", l1, vecs[k].exp_left);
      checkOutput("vec_right", r1, vecs[k].exp_right);
      checkOutput("vec_gain_hold", g1, vecs[k].vol);
    end

    // Clip counting at unity
    volume = 9'd256;
    settleGain(1'b0, 9'd256);
    tick();
    clear_clip = 1'b1;
    tick();
    clear_clip = 1'b0;
    checkOutput("clip_clear_l", cl1, 0);
    checkOutput("clip_clear_r", cr1, 0);
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0);
    tick();
    checkOutput("clip_out_r", r1, 32'h8000_0000);
    checkOutput("clip_pos_l", cl1, 1);
    checkOutput("clip_neg_r", cr1, 1);
    applyStimulus(32'h7EFF_FFFF, 32'h8100_0001, 1'b1);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0);
    tick();
    checkOutput("noclip_l", cl1, 1);
    checkOutput("noclip_r", cr1, 1);
    applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    clear_clip = 1'b1;
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0);
    tick();
    clear_clip = 1'b0;
    tick();
    checkOutput("clear_prio_l", cl1, 0);
    checkOutput("clear_prio_r", cr1, 0);
    force dut1.clip_cnt_left_q = 16'hFFFE;
    force dut1.clip_cnt_right_q = 16'hFFFE;
    tick();
    release dut1.clip_cnt_left_q;
    release dut1.clip_cnt_right_q;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
      tick();
    end
    applyStimulus(32'd0, 32'd0, 1'b0);
    tick();
    tick();
    checkOutput("clip_sat_l", cl1, 16'hFFFF);
    checkOutput("clip_sat_r", cr1, 16'hFFFF);

    // Clamp and redirect at STEP=16
    volume = 9'd300;
    settleGain(1'b1, 9'd256);
    checkOutput("clamp_state", s16, 2);
    volume = 9'd200;
    settleGain(1'b1, 9'd200);
    volume = 9'd128;
    for (int r = 0; r < 6; r++) begin
      applyStimulus(32'd0, 32'd0, 1'b1);
      tick();
      checkOutput("redir_gain", g16, (r < 4) ? 184 - 16 * r : 128);
      checkOutput("redir_state", s16, (r < 4) ? 3 : 2);
      checkOutput("redir_done", rd16, (r == 4) ? 1 : 0);
    end
    applyStimulus(32'd0, 32'd0, 1'b0);

    // Gaps freeze the ramp
    mute_req = 1'b1;
    settleGain(1'b0, 9'd0);
    mute_req = 1'b0;
    volume   = 9'd256;
    exp_g    = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(32'h1000_0000, 32'h1000_0000, (i % 3) != 1);
      tick();
      if ((i % 3) != 1) exp_g++;
      checkOutput("gap_gain", g1, exp_g);
      checkOutput("gap_state", s1, 1);
    end

    // Asynchronous reset mid-ramp with samples in flight
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h1000_0000, 32'h1000_0000, 1'b1);
      tick();
    end
    checkOutput("pre_rst_valid", v1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_left", l1, 0);
    checkOutput("arst_right", r1, 0);
    checkOutput("arst_valid", v1, 0);
    checkOutput("arst_gain", g1, 0);
    checkOutput("arst_state", s1, 0);
    checkOutput("arst_clip_l", cl1, 0);
    checkOutput("arst_clip_r", cr1, 0);
    applyStimulus(32'd0, 32'd0, 1'b0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post_rst_valid", v1, 0);
      checkOutput("post_rst_gain", g1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_soft_mute.md
# output_soft_mute

Per-channel gain and soft-mute stage between the luxury-features output (main 32-bit stereo stream) and the analog output stage. It ramps gain linearly, one step per valid sample, toward a target set by `volume` and `mute_req`, so mute, unmute and volume changes never step the output. It also flags near-full-scale output samples in saturating per-channel clip counters. It runs entirely in the `clk_dac_hs` domain.

## Interface
- `STEP`, default 1: gain change per valid sample, range 1..256.
- `CLIP_THRESH`, default 32'h7F00_0000: unsigned magnitude at or above which an output sample counts as a clip.

Ports:
- `clk_dac_hs` in 1: processing clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `audio_left_in` in 32: signed two's-complement sample.
- `audio_right_in` in 32: signed two's-complement sample.
- `audio_valid_in` in 1: one-cycle strobe per stereo sample.
- `mute_req` in 1: 1 = target gain 0.
- `volume` in 9: target gain, unity = 256; values above 256 clamp to 256.
- `clear_clip` in 1: synchronous clear of both clip counters.
- `audio_left_out` out 32: gained sample.
- `audio_right_out` out 32: gained sample.
- `audio_valid_out` out 1: one-cycle strobe.
- `gain_out` out 9: current gain register.
- `state_out` out 2: 0 MUTED, 1 RAMP_UP, 2 ACTIVE, 3 RAMP_DOWN.
- `ramp_done` out 1: one-cycle pulse on entering MUTED or ACTIVE from a ramp state.
- `clip_count_left` out 16: saturating count of clipped left samples.
- `clip_count_right` out 16: saturating count of clipped right samples.

## Operation
- **Target.** `target = mute_req ? 0 : min(volume, 256)`, evaluated on every cycle with `audio_valid_in`=1. `mute_req` and `volume` are ignored on other cycles.
- **Gain update,** on each valid cycle:
  - If `gain < target`: `gain += min(STEP, target-gain)`.
  - If `gain > target`: `gain -= min(STEP, gain-target)`.
  - Otherwise gain holds.
  - Gain never overshoots the target.
- **State.** Registered on the same valid cycle from the post-update gain:
  - `new_gain == target`: MUTED if target = 0, else ACTIVE.
  - `new_gain < target`: RAMP_UP.
  - `new_gain > target`: RAMP_DOWN.
  - A target change mid-ramp redirects the ramp immediately; there is no wait for completion.
- **ramp_done.** Asserted for exactly one cycle when the state goes from RAMP_UP or RAMP_DOWN to MUTED or ACTIVE. A direct transition such as ACTIVE to ACTIVE with a new equal target raises no pulse.
- **Arithmetic:**
  - The sample taken on a valid cycle is scaled by the pre-update gain.
  - Signed 32-bit × unsigned 9-bit gives a 41-bit signed product.
  - Result = product >>> 8 (arithmetic shift, truncation toward −∞), low 32 bits.
  - Because gain ≤ 256, the result cannot overflow 32 bits.
- **Clip detect.**
  - Magnitude = |out|, computed as a 33-bit value so that 32'h8000_0000 gives 2^31.
  - A clip is magnitude ≥ `CLIP_THRESH`, checked per channel.
  - Counting happens only on `audio_valid_out` cycles.
  - Counters saturate at 16'hFFFF.
  - `clear_clip` takes priority: if it coincides with a clip event the counter becomes 0.
- **Gaps.** Gaps in `audio_valid_in` freeze the gain and state. Ramp length is measured in samples, not cycles.

## Timing
- **Reset values.** All outputs are 0: outputs, valid, `gain_out`, `state_out` (MUTED), `ramp_done`, both counters. Pipeline valid bits are 0.
- **After reset.** The block always starts MUTED. With `mute_req`=0 it ramps up from the first valid sample.
- **Pipeline, latency 2 cycles:**
  - Valid sample at cycle t.
  - Product registered at t+1.
  - Shifted result, `audio_valid_out`, and clip counter update at t+2.
  - `gain_out`, `state_out` and `ramp_done` update at t+1.
- **Throughput.** One sample per cycle; back-to-back valid strobes are supported.
- **Reset mid-operation.** Asynchronous clear; pipeline contents are discarded and no valid output is produced from in-flight samples.

## Test plan
1. **Ramp up from reset.** Release reset; `mute_req`=0, `volume`=256, `STEP`=1, constant input 32'h1000_0000 on every cycle.
   - Output for the k-th sample (k from 0) = 32'h1000_0000·k>>8: first output 0, second 32'h0010_0000.
   - Sample 256 onward outputs 32'h1000_0000.
   - `ramp_done` pulses at the cycle `gain_out` reaches 256; `state_out` goes 1 → 2.
2. **Mute from ACTIVE.** Assert `mute_req` from ACTIVE at gain 256.
   - State is 3 for 255 samples, then 0.
   - Output reaches 0 exactly; `ramp_done` pulses once.
3. **Signed arithmetic.** At gain 128:
   - −32'h1000_0000 → −32'h0800_0000.
   - −1 → −1 (floor).
   - 32'h7FFF_FFFF → 32'h3FFF_FFFF.
4. **Clamp and redirect.** `volume`=300 settles at gain 256. Then `volume`=128 mid-ramp while at gain 200 with `STEP`=16:
   - Gain sequence 184, 168, 152, 136, 128; state 3 then 2.
   - No overshoot.
5. **Clip counting at unity:**
   - 32'h7FFF_FFFF and 32'h8000_0000 each increment their channel's counter.
   - 32'h7EFF_FFFF does not.
   - `clear_clip` coincident with a clip gives 0.
   - A forced 16'hFFFF holds under further clips.
6. **Gaps and reset.** Toggle `audio_valid_in` with gaps mid-ramp: gain advances only on valid cycles. Pulse `rst_n` mid-ramp:
   - All outputs read 0 within the same cycle.
   - No `audio_valid_out` for samples in flight.
